// File: rtl/core_mem_responder.sv
// core_mem_responder: memory-side responder for the core's data-memory port.
// It serves one request at a time from a local word-addressed store, adds
// programmable wait states, and signals completion with a one-cycle
// ready_sig pulse.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset (0 = in reset)
//   enable     2'b00 idle, 2'b01 read, 2'b10 write, 2'b11 illegal
//   addr       word address of request
//   wr_data    write data
//   rd_data    read data; valid while ready_sig=1 for a read, held otherwise
//   ready_sig  one-cycle completion pulse for the accepted request
//   busy       request accepted and not yet completed
//   err        sticky: illegal enable or out-of-range address seen
//   err_clr    synchronous clear of err (a simultaneous set wins)
module core_mem_responder #(
    parameter int unsigned REG_SIZE  = 8,
    parameter int unsigned ADDR_SIZE = 8,
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned RD_WAIT   = 2,
    parameter int unsigned WR_WAIT   = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           enable,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [REG_SIZE-1:0]  wr_data,
    output logic [REG_SIZE-1:0]  rd_data,
    output logic                 ready_sig,
    output logic                 busy,
    output logic                 err,
    input  logic                 err_clr
);

    localparam int unsigned MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CNT_W  = 4;

    localparam logic [CNT_W-1:0] RD_CNT = CNT_W'(RD_WAIT);
    localparam logic [CNT_W-1:0] WR_CNT = CNT_W'(WR_WAIT);

    localparam logic [1:0] EN_IDLE    = 2'b00;
    localparam logic [1:0] EN_READ    = 2'b01;
    localparam logic [1:0] EN_WRITE   = 2'b10;
    localparam logic [1:0] EN_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 op_wr_q, op_wr_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [REG_SIZE-1:0]  wdata_q, wdata_d;
    logic [REG_SIZE-1:0]  rd_data_d;
    logic                 ready_d;
    logic                 busy_d;
    logic                 err_d;

    logic [REG_SIZE-1:0]  mem [MEM_DEPTH];

    // Range check and store index for the request currently held (or being captured)
    logic                 addr_ok_d, addr_ok_q;
    logic [MEM_AW-1:0]    idx_d, idx_q;

    assign addr_ok_d = 32'(addr_d) < MEM_DEPTH;
    assign idx_d     = MEM_AW'(addr_d);
    assign addr_ok_q = 32'(addr_q) < MEM_DEPTH;
    assign idx_q     = MEM_AW'(addr_q);

    // State register and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rd_data   <= '0;
            ready_sig <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_wr_q   <= op_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rd_data   <= rd_data_d;
            ready_sig <= ready_d;
            busy      <= busy_d;
            err       <= err_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_wr_d   = op_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data;
        ready_d   = 1'b0;
        busy_d    = 1'b0;
        err_d     = err_clr ? 1'b0 : err;

        unique case (state_q)
            IDLE: begin
                unique case (enable)
                    EN_READ, EN_WRITE: begin
                        op_wr_d = (enable == EN_WRITE);
                        addr_d  = addr;
                        wdata_d = wr_data;
                        cnt_d   = (enable == EN_WRITE) ? WR_CNT : RD_CNT;
                        state_d = (cnt_d == '0) ? DONE : WAIT;
                    end
                    EN_ILLEGAL: err_d = 1'b1;
                    EN_IDLE:    state_d = IDLE;
                    default:    state_d = IDLE;
                endcase
            end
            WAIT: begin
                // Captured request only; live inputs are ignored here
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Completion cycle outputs are prepared on the edge that enters DONE
        if (state_d == DONE) begin
            ready_d = 1'b1;
            if (!op_wr_d) begin
                rd_data_d = addr_ok_d ? mem[idx_d] : '0;
            end
            if (!addr_ok_d) begin
                err_d = 1'b1;
            end
        end

        busy_d = (state_d != IDLE);
    end

    // Write commits on the edge that ends DONE; out-of-range writes are dropped
    always_ff @(posedge clk) begin
        if (state_q == DONE && op_wr_q && addr_ok_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

endmodule
